// File: rtl/life_scan_ctrl.sv
// life_scan_ctrl: row-multiplexed LED scan of the 16x16 Life grid plus
// generation pacing (free-run every GEN_FRAMES frames, pause, single-step).
// Frame sequence: SNAP (latch grid), then per row DWELL SCAN cycles + 1 BLANK.
// gen_tick only ever fires in the last-row BLANK, so the SNAP that follows
// always latches a complete, single generation.
// Optional: define LIFE_GEN_COUNTER_EN to add the 16-bit gen_count output.
module life_scan_ctrl #(
   parameter int ROWS       = 16,
   parameter int COLS       = 16,
   parameter int DWELL      = 1024,
   parameter int GEN_FRAMES = 8
) (
   input  logic                            Clock,
   input  logic                            reset,
   input  logic [ROWS*COLS-1:0]            grid_in,
   input  logic                            pause,
   input  logic                            step_req,
   output logic                            gen_tick,
   output logic [ROWS-1:0]                 row_sel,
   output logic [COLS-1:0]                 col_data,
   output logic                            frame_start,
   output logic [$clog2(GEN_FRAMES):0]     frame_count
`ifdef LIFE_GEN_COUNTER_EN
   ,
   output logic [15:0]                     gen_count
`endif
);

   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DW  = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int FCW = $clog2(GEN_FRAMES) + 1;

   typedef enum logic [1:0] {SNAP, SCAN, BLANK} state_t;

   state_t                 state_q, state_d;
   logic [RW-1:0]          row_q, row_d;
   logic [DW-1:0]          dwell_q, dwell_d;
   logic [FCW-1:0]         fc_q, fc_d;
   logic                   pending_q, pending_d;
   logic [ROWS*COLS-1:0]   buffer_q, buffer_d;
   logic [ROWS-1:0]        row_sel_q, row_sel_d;
   logic [COLS-1:0]        col_data_q, col_data_d;
   logic                   frame_start_q, frame_start_d;
   logic                   frame_end;
   logic                   tick_c;
`ifdef LIFE_GEN_COUNTER_EN
   logic [15:0]            gen_count_q, gen_count_d;
`endif

   // Next-state, generation and registered-output logic for the scan FSM.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      dwell_d   = dwell_q;
      fc_d      = fc_q;
      pending_d = pending_q;
      buffer_d  = buffer_q;
      tick_c    = 1'b0;
      frame_end = (state_q == BLANK) && (row_q == RW'(ROWS - 1));

      case (state_q)
         SNAP: begin
            buffer_d = grid_in;
            row_d    = '0;
            dwell_d  = '0;
            state_d  = SCAN;
         end
         SCAN: begin
            if (dwell_q == DW'(DWELL - 1)) begin
               dwell_d = '0;
               state_d = BLANK;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         BLANK: begin
            if (!frame_end) begin
               row_d   = row_q + 1'b1;
               state_d = SCAN;
            end else begin
               state_d = SNAP;
               if (fc_q == FCW'(GEN_FRAMES - 1))
                  fc_d = '0;
               else
                  fc_d = fc_q + 1'b1;
               // A pending step left over from a pause still gets honoured
               // once at the frame end even if pause has since dropped.
               if (pause)
                  tick_c = pending_q | step_req;
               else
                  tick_c = (fc_q == FCW'(GEN_FRAMES - 1)) | pending_q;
               pending_d = 1'b0;
            end
         end
         default: state_d = SNAP;
      endcase

      if (!frame_end && pause && step_req)
         pending_d = 1'b1;

      // Outputs are registered, so they are derived from the next state.
      frame_start_d = (state_d == SNAP);
      row_sel_d     = '0;
      col_data_d    = '0;
      if (state_d == SCAN) begin
         row_sel_d  = ROWS'(1) << row_d;
         col_data_d = buffer_d[row_d*COLS +: COLS];
      end

`ifdef LIFE_GEN_COUNTER_EN
      gen_count_d = gen_count_q + {15'd0, tick_c};
`endif
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clock) begin
      if (reset) begin
         state_q       <= SNAP;
         row_q         <= '0;
         dwell_q       <= '0;
         fc_q          <= '0;
         pending_q     <= 1'b0;
         buffer_q      <= '0;
         row_sel_q     <= '0;
         col_data_q    <= '0;
         frame_start_q <= 1'b0;
`ifdef LIFE_GEN_COUNTER_EN
         gen_count_q   <= '0;
`endif
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         dwell_q       <= dwell_d;
         fc_q          <= fc_d;
         pending_q     <= pending_d;
         buffer_q      <= buffer_d;
         row_sel_q     <= row_sel_d;
         col_data_q    <= col_data_d;
         frame_start_q <= frame_start_d;
`ifdef LIFE_GEN_COUNTER_EN
         gen_count_q   <= gen_count_d;
`endif
      end
   end

   // gen_tick is combinational so a step request in the frame-end cycle acts at once.
   assign gen_tick    = tick_c & ~reset;
   assign row_sel     = row_sel_q;
   assign col_data    = col_data_q;
   assign frame_start = frame_start_q;
   assign frame_count = fc_q;
`ifdef LIFE_GEN_COUNTER_EN
   assign gen_count   = gen_count_q;
`endif

endmodule

// File: tb/tb_life_scan_ctrl.sv
// Directed bench for life_scan_ctrl with ROWS=16, COLS=16, DWELL=4, GEN_FRAMES=2.
// Frame k (1-based after reset release) occupies cycles 81(k-1)+1 .. 81k;
// its SNAP is the first cycle, its last-row BLANK the last cycle.
module tb_life_scan_ctrl;

   logic          Clock;
   logic          reset;
   logic [255:0]  grid_in;
   logic          pause;
   logic          step_req;
   logic          gen_tick;
   logic [15:0]   row_sel;
   logic [15:0]   col_data;
   logic          frame_start;
   logic [1:0]    frame_count;
`ifdef LIFE_GEN_COUNTER_EN
   logic [15:0]   gen_count;
`endif

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   life_scan_ctrl #(.ROWS(16), .COLS(16), .DWELL(4), .GEN_FRAMES(2)) dut (
      .Clock       (Clock),
      .reset       (reset),
      .grid_in     (grid_in),
      .pause       (pause),
      .step_req    (step_req),
      .gen_tick    (gen_tick),
      .row_sel     (row_sel),
      .col_data    (col_data),
      .frame_start (frame_start),
      .frame_count (frame_count)
`ifdef LIFE_GEN_COUNTER_EN
      ,
      .gen_count   (gen_count)
`endif
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic tick();
      @(posedge Clock);
      #1;
      cyc++;
   endtask

   task automatic goto_cyc(input int n);
      while (cyc < n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
         $display("[TB] cyc %0d %s ok (%h)", cyc, tag, obs);
      else begin
         fails++;
         $error("FAIL %s at cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   initial begin
      reset    = 1'b1;
      pause    = 1'b0;
      step_req = 1'b0;
      grid_in  = '0;
      grid_in[0]   = 1'b1;
      grid_in[255] = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      cyc   = 1;               // first SNAP cycle after release

      // Reset state / first SNAP
      chk("rst_row_sel", 32'(row_sel), 32'h0);
      chk("rst_col_data", 32'(col_data), 32'h0);
      chk("rst_gen_tick", 32'(gen_tick), 32'h0);
      chk("rst_frame_cnt", 32'(frame_count), 32'h0);
      goto_cyc(2);
      chk("row0_sel_c2", 32'(row_sel), 32'h0001);
      chk("row0_col_c2", 32'(col_data), 32'h0001);
      goto_cyc(5);
      chk("row0_sel_c5", 32'(row_sel), 32'h0001);
      goto_cyc(6);
      chk("blank0_sel", 32'(row_sel), 32'h0);
      chk("blank0_col", 32'(col_data), 32'h0);
      goto_cyc(7);
      chk("row1_sel", 32'(row_sel), 32'h0002);
      goto_cyc(77);
      chk("row15_sel", 32'(row_sel), 32'h8000);
      chk("row15_col", 32'(col_data), 32'h8000);
      goto_cyc(81);
      chk("f1_end_tick", 32'(gen_tick), 32'h0);
      chk("f1_end_sel", 32'(row_sel), 32'h0);
      goto_cyc(82);
      chk("f2_frame_start", 32'(frame_start), 32'h1);
      chk("f2_frame_cnt", 32'(frame_count), 32'h1);
      goto_cyc(83);
      chk("f2_fs_low", 32'(frame_start), 32'h0);

      // Grid changes mid-frame: old pattern persists until next SNAP
      grid_in = '0;
      grid_in[16] = 1'b1;
      goto_cyc(84);
      chk("midchg_row0_old", 32'(col_data), 32'h0001);
      goto_cyc(88);
      chk("midchg_row1_old", 32'(col_data), 32'h0000);
      goto_cyc(158);
      chk("midchg_row15_old", 32'(col_data), 32'h8000);
      goto_cyc(161);
      chk("f2_pre_end_tick", 32'(gen_tick), 32'h0);
      goto_cyc(162);
      chk("f2_end_tick", 32'(gen_tick), 32'h1);
      chk("f2_end_sel", 32'(row_sel), 32'h0);
      goto_cyc(163);
      chk("f3_frame_start", 32'(frame_start), 32'h1);
      chk("f3_tick_low", 32'(gen_tick), 32'h0);
      chk("f3_frame_cnt", 32'(frame_count), 32'h0);
      goto_cyc(164);
      chk("newgrid_row0", 32'(col_data), 32'h0000);
      goto_cyc(169);
      chk("newgrid_row1_sel", 32'(row_sel), 32'h0002);
      chk("newgrid_row1_col", 32'(col_data), 32'h0001);
      goto_cyc(243);
      chk("f3_end_tick", 32'(gen_tick), 32'h0);
      goto_cyc(250);
      chk("f4_frame_cnt", 32'(frame_count), 32'h1);
      goto_cyc(324);
      chk("f4_end_tick", 32'(gen_tick), 32'h1);
      goto_cyc(325);
      chk("f5_tick_low", 32'(gen_tick), 32'h0);
`ifdef LIFE_GEN_COUNTER_EN
      chk("gen_count_2", 32'(gen_count), 32'd2);
`endif

      // Paused: step in frame 6 (two pulses -> one tick)
      pause = 1'b1;
      goto_cyc(405);
      chk("p_f5_end_tick", 32'(gen_tick), 32'h0);
      goto_cyc(430);
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      goto_cyc(440);
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      goto_cyc(486);
      chk("p_f6_step_tick", 32'(gen_tick), 32'h1);
      goto_cyc(487);
      chk("p_f7_tick_low", 32'(gen_tick), 32'h0);
      goto_cyc(567);
      chk("p_f7_end_tick", 32'(gen_tick), 32'h0);
      goto_cyc(600);
      chk("p_f8_frame_cnt", 32'(frame_count), 32'h1);
      goto_cyc(648);
      chk("p_f8_auto_suppr", 32'(gen_tick), 32'h0);
      goto_cyc(729);
      step_req = 1'b1;
      #1;
      chk("p_f9_step_same", 32'(gen_tick), 32'h1);
      tick();
      step_req = 1'b0;
      chk("p_f10_tick_low", 32'(gen_tick), 32'h0);
`ifdef LIFE_GEN_COUNTER_EN
      chk("gen_count_4", 32'(gen_count), 32'd4);
`endif

      // Free-run: step while unpaused is ignored
      pause = 1'b0;
      goto_cyc(740);
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      goto_cyc(810);
      chk("f10_auto_tick", 32'(gen_tick), 32'h1);
      goto_cyc(811);
      pause = 1'b1;
      goto_cyc(891);
      chk("f11_ignored_step", 32'(gen_tick), 32'h0);
      goto_cyc(972);
      chk("f12_auto_suppr", 32'(gen_tick), 32'h0);

      // Pending step survives pause falling; honoured once at frame end
      goto_cyc(980);
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      goto_cyc(1000);
      pause = 1'b0;
      goto_cyc(1053);
      chk("f13_pending_tick", 32'(gen_tick), 32'h1);
      goto_cyc(1054);
      chk("f14_frame_cnt", 32'(frame_count), 32'h1);

      // Reset during row 7 SCAN of frame 14 with pending set and frame_count=1
      pause = 1'b1;
      goto_cyc(1060);
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      goto_cyc(1091);
      chk("pre_rst_row7", 32'(row_sel), 32'h0080);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("post_rst_sel", 32'(row_sel), 32'h0);
      chk("post_rst_col", 32'(col_data), 32'h0);
      chk("post_rst_fs", 32'(frame_start), 32'h0);
      chk("post_rst_fc", 32'(frame_count), 32'h0);
      chk("post_rst_tick", 32'(gen_tick), 32'h0);
`ifdef LIFE_GEN_COUNTER_EN
      chk("post_rst_gen_count", 32'(gen_count), 32'd0);
`endif
      goto_cyc(1093);
      chk("post_rst_row0", 32'(row_sel), 32'h0001);
      chk("post_rst_col0", 32'(col_data), 32'h0000);
      goto_cyc(1172);
      chk("post_rst_pending_clr", 32'(gen_tick), 32'h0);
      goto_cyc(1173);
      chk("post_rst_fs_next", 32'(frame_start), 32'h1);
      chk("post_rst_fc_next", 32'(frame_count), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
